// File: rtl/jalu_pkg.sv
// Shared definitions for the jALU multiply sequencer.
//   - ALU opcode encodings (only ADD and SHR are issued by the sequencer).
//   - 3-bit FSM state encoding for jalu_mul_seq.
package jalu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHP  = 3'd2,
    S_SHL  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/jalu_mul_seq_if.sv
// Bundle of the request/response handshake and the ALU drive/sample signals of jalu_mul_seq.
//   Request : wreqv (valid), wreqr (ready), bma (multiplicand), bmb (multiplier)
//   Response: wrspv (valid), wrspr (ready), bprod (16-bit product {P,L})
//   ALU     : bas, bbs, wci, bops driven by the sequencer; bcs, wco returned by the ALU
//   Flags   : wpz, wphi only when JALU_MUL_SEQ_FLAGS_EN is defined
// Modports: slave = sequencer side, master = requester/ALU side.
interface jalu_mul_seq_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 wreqv;
  logic                 wreqr;
  logic [WIDTH-1:0]     bma;
  logic [WIDTH-1:0]     bmb;
  logic                 wrspv;
  logic                 wrspr;
  logic [2*WIDTH-1:0]   bprod;
  logic [WIDTH-1:0]     bas;
  logic [WIDTH-1:0]     bbs;
  logic                 wci;
  logic [2:0]           bops;
  logic [WIDTH-1:0]     bcs;
  logic                 wco;
`ifdef JALU_MUL_SEQ_FLAGS_EN
  logic                 wpz;
  logic                 wphi;
`endif

  modport slave (
    input  wreqv, bma, bmb, wrspr, bcs, wco,
    output wreqr, wrspv, bprod, bas, bbs, wci, bops
`ifdef JALU_MUL_SEQ_FLAGS_EN
    , output wpz, wphi
`endif
  );

  modport master (
    output wreqv, bma, bmb, wrspr, bcs, wco,
    input  wreqr, wrspv, bprod, bas, bbs, wci, bops
`ifdef JALU_MUL_SEQ_FLAGS_EN
    , input wpz, wphi
`endif
  );

endinterface

// File: rtl/jalu_mul_seq.sv
// Shift-and-add 8x8->16 unsigned multiplier sequencer driving an external shared jALU.
// One ALU op per clock; the ALU result (bcs) and carry (wco) are captured at the next edge.
// Per multiplier bit: optional ADD (P += M), SHR of P with carry-in c, SHR of L with the bit
// shifted out of P. Latency accept->wrspv = 16 + popcount(bmb).
// Ports:
//   wclk  - clock, rising edge
//   wrstn - asynchronous active-low reset
//   bus   - jalu_mul_seq_if.slave (handshake, product, ALU drive/sample, optional flags)
// Optional macro JALU_MUL_SEQ_FLAGS_EN adds wpz (product==0) and wphi (high byte nonzero),
// registered on entry to DONE and cleared on the next accept.
module jalu_mul_seq
  import jalu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic            wclk,
  input logic            wrstn,
  jalu_mul_seq_if.slave  bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     l_q, l_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 c_q, c_d;
  logic                 s_q, s_d;
  logic [2:0]           cnt_q, cnt_d;
  // Separate product register so bprod stays put while P/L are reused by the next operation.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
`ifdef JALU_MUL_SEQ_FLAGS_EN
  logic                 wpz_q, wpz_d;
  logic                 wphi_q, wphi_d;
`endif

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef JALU_MUL_SEQ_FLAGS_EN
      wpz_q   <= 1'b0;
      wphi_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      l_q     <= l_d;
      m_q     <= m_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef JALU_MUL_SEQ_FLAGS_EN
      wpz_q   <= wpz_d;
      wphi_q  <= wphi_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    l_d       = l_q;
    m_d       = m_q;
    c_d       = c_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
`ifdef JALU_MUL_SEQ_FLAGS_EN
    wpz_d     = wpz_q;
    wphi_d    = wphi_q;
`endif
    bus.wreqr = 1'b0;
    bus.wrspv = 1'b0;
    bus.bas   = '0;
    bus.bbs   = '0;
    bus.wci   = 1'b0;
    bus.bops  = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        bus.wreqr = 1'b1;
        if (bus.wreqv) begin
          m_d     = bus.bma;
          l_d     = bus.bmb;
          p_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
`ifdef JALU_MUL_SEQ_FLAGS_EN
          wpz_d   = 1'b0;
          wphi_d  = 1'b0;
`endif
          state_d = bus.bmb[0] ? S_ADD : S_SHP;
        end
      end
      S_ADD: begin
        bus.bops = ALU_ADD;
        bus.bas  = p_q;
        bus.bbs  = m_q;
        p_d      = bus.bcs;
        c_d      = bus.wco;
        state_d  = S_SHP;
      end
      S_SHP: begin
        // ADD carry enters P's MSB; P's LSB falls out into s.
        bus.bops = ALU_SHR;
        bus.bas  = p_q;
        bus.wci  = c_q;
        p_d      = bus.bcs;
        s_d      = bus.wco;
        state_d  = S_SHL;
      end
      S_SHL: begin
        bus.bops = ALU_SHR;
        bus.bas  = l_q;
        bus.wci  = s_q;
        l_d      = bus.bcs;
        c_d      = 1'b0;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          prod_d  = {p_q, bus.bcs};
`ifdef JALU_MUL_SEQ_FLAGS_EN
          wpz_d   = (p_q == '0) && (bus.bcs == '0);
          wphi_d  = (p_q != '0);
`endif
          state_d = S_DONE;
        end else begin
          // bcs[0] is the next multiplier bit after this shift.
          state_d = bus.bcs[0] ? S_ADD : S_SHP;
        end
      end
      S_DONE: begin
        bus.wrspv = 1'b1;
        if (bus.wrspr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.bprod = prod_q;
`ifdef JALU_MUL_SEQ_FLAGS_EN
  assign bus.wpz  = wpz_q;
  assign bus.wphi = wphi_q;
`endif

endmodule

// File: tb/tb_jalu_mul_seq.sv
// Bench for jalu_mul_seq paired with a behavioural jALU. Expected products and latencies come
// from plain arithmetic (a*b, 16 + popcount(b)).
module tb_jalu_mul_seq;
  import jalu_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jalu_mul_seq_if #(.WIDTH(8)) bus ();

  jalu_mul_seq #(.WIDTH(8)) dut (
    .wclk  (clk),
    .wrstn (rstn),
    .bus   (bus)
  );

  // Behavioural jALU.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.bas} + {1'b0, bus.bbs} + {8'd0, bus.wci};
    bus.bcs = '0;
    bus.wco = 1'b0;
    case (bus.bops)
      ALU_ADD: {bus.wco, bus.bcs} = alu_sum;
      ALU_SHR: begin bus.bcs = {bus.wci, bus.bas[7:1]}; bus.wco = bus.bas[0]; end
      ALU_SHL: begin bus.bcs = {bus.bas[6:0], bus.wci}; bus.wco = bus.bas[7]; end
      ALU_NOT: bus.bcs = ~bus.bas;
      ALU_AND: bus.bcs = bus.bas & bus.bbs;
      ALU_OR:  bus.bcs = bus.bas | bus.bbs;
      ALU_XOR: bus.bcs = bus.bas ^ bus.bbs;
      default: bus.bcs = bus.bas - bus.bbs;
    endcase
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: optional idle gap, accept, busy phase, hold in DONE, release.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int pre,
                       input int hold, input bit poke);
    int          lat;
    int          exp_lat;
    bit          bad_op;
    bit          bad_rdy;
    bit          bad_hold;
    logic [15:0] exp_p;
    exp_p   = 16'(a) * 16'(b);
    exp_lat = 16 + $countones(b);
    repeat (pre) step();
    check("idle_ready", 32'(bus.wreqr), 32'd1);
    bus.bma   = a;
    bus.bmb   = b;
    bus.wreqv = 1'b1;
    step();
    bus.wreqv = 1'b0;
    lat     = 0;
    bad_op  = 1'b0;
    bad_rdy = 1'b0;
    while (!bus.wrspv && lat < 40) begin
      if (!(bus.bops inside {ALU_ADD, ALU_SHR})) bad_op = 1'b1;
      if (bus.wreqr) bad_rdy = 1'b1;
      if (poke) begin
        bus.wreqv = 1'($urandom);
        bus.wrspr = 1'($urandom);
        bus.bma   = 8'($urandom);
        bus.bmb   = 8'($urandom);
      end
      step();
      lat++;
    end
    bus.wrspr = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_ops", 32'(bad_op), 32'd0);
    check("busy_ready", 32'(bad_rdy), 32'd0);
    check("product", 32'(bus.bprod), 32'(exp_p));
`ifdef JALU_MUL_SEQ_FLAGS_EN
    check("wpz", 32'(bus.wpz), 32'(exp_p == 16'd0));
    check("wphi", 32'(bus.wphi), 32'(exp_p > 16'd255));
`endif
    bad_hold = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.wreqv = 1'($urandom);
      bus.bma   = 8'($urandom);
      bus.bmb   = 8'($urandom);
      step();
      if (!bus.wrspv || bus.wreqr || bus.bprod !== exp_p) bad_hold = 1'b1;
    end
    if (hold > 0) check("hold_stable", 32'(bad_hold), 32'd0);
    bus.wrspr = 1'b1;
    step();
    bus.wrspr = 1'b0;
    bus.wreqv = 1'b0;
    check("rsp_drop", 32'(bus.wrspv), 32'd0);
    check("ready_again", 32'(bus.wreqr), 32'd1);
    check("prod_kept", 32'(bus.bprod), 32'(exp_p));
  endtask

  initial begin
    bus.wreqv = 1'b0;
    bus.wrspr = 1'b0;
    bus.bma   = '0;
    bus.bmb   = '0;
    #2;
    check("rst_ready", 32'(bus.wreqr), 32'd1);
    check("rst_rspv", 32'(bus.wrspv), 32'd0);
    check("rst_prod", 32'(bus.bprod), 32'd0);
    check("rst_ops", 32'(bus.bops), 32'(ALU_ADD));
    check("rst_alu", 32'({bus.bas, bus.bbs, bus.wci}), 32'd0);
`ifdef JALU_MUL_SEQ_FLAGS_EN
    check("rst_flags", 32'({bus.wpz, bus.wphi}), 32'd0);
`endif
    #10;
    rstn = 1'b1;
    step();

    // Directed cases.
    do_op(8'd13, 8'd11, 0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1, 0, 1'b0);
    do_op(8'h5A, 8'h00, 0, 0, 1'b0);
    do_op(8'h00, 8'h81, 0, 0, 1'b0);
    // Back-pressure with ignored requests, then a second request.
    do_op(8'hC3, 8'h5D, 0, 10, 1'b1);
    do_op(8'h21, 8'h07, 0, 0, 1'b0);

    // Reset in the middle of 0x80*0x80.
    bus.bma   = 8'h80;
    bus.bmb   = 8'h80;
    bus.wreqv = 1'b1;
    step();
    bus.wreqv = 1'b0;
    repeat (6) step();
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_rspv", 32'(bus.wrspv), 32'd0);
    check("midrst_prod", 32'(bus.bprod), 32'd0);
    check("midrst_ops", 32'(bus.bops), 32'(ALU_ADD));
    check("midrst_ready", 32'(bus.wreqr), 32'd1);
    step();
    step();
    #2;
    rstn = 1'b1;
    step();
    do_op(8'h80, 8'h80, 0, 0, 1'b0);

    // Randomized pairs with stalls on both sides.
    for (int n = 0; n < 1000; n++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
